// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage. It owns
// the HI/LO register pair, stalls the pipeline while an operation runs,
// commits HI/LO in one completion cycle, and also services MTHI/MTLO writes.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   alucontrolE  decoded ALU control code from the decoder
//   srcaE        rs operand (dividend / multiplicand / MTHI-MTLO data)
//   srcbE        rt operand (divisor / multiplier)
//   flushE       E-stage flush (exception or branch)
//   stall_mdE    pipeline stall request (combinational)
//   done_o       one-cycle pulse in the completion cycle
//   hi_o, lo_o   HI and LO registers
module muldiv_hilo_ctrl #(
  parameter int         MUL_LAT       = 3,
  parameter int         DIV_STEPS     = 32,
  // Control encodings; override to match the decoder's defines.h values.
  parameter logic [4:0] MULT_CONTROL  = 5'b01000,
  parameter logic [4:0] MULTU_CONTROL = 5'b01001,
  parameter logic [4:0] DIV_CONTROL   = 5'b01010,
  parameter logic [4:0] DIVU_CONTROL  = 5'b01011,
  parameter logic [4:0] MTHI_CONTROL  = 5'b01100,
  parameter logic [4:0] MTLO_CONTROL  = 5'b01101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrolE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  output logic        stall_mdE,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // With a one-cycle multiply the MUL state is skipped and DONE reads the
  // multiplier output directly instead of the registered product.
  localparam bit         MUL_DIRECT   = (MUL_LAT == 1);
  localparam logic [5:0] MUL_CNT_INIT = (MUL_LAT > 1) ? 6'(MUL_LAT - 2) : 6'd0;
  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_STEPS - 1);

  // Two's-complement magnitude; 0x80000000 maps onto itself as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] mag_a_r, mag_b_r, quo_r, rem_r, hi_r, lo_r;
  logic [63:0] prod_r;
  logic [5:0]  cnt_r;
  logic        sign_a_r, sign_b_r, is_div_r;

  logic        is_mul_s, is_div_s, op_signed_s, start_s;
  logic [32:0] rem_shift_s, rem_diff_s;
  logic [63:0] mult_s, prod_sel_s, prod_fix_s;
  logic [31:0] quo_fix_s, rem_fix_s, raw_a_s, commit_hi_s, commit_lo_s;

  // Operation decode and the divide/multiply datapath shared by all states.
  always_comb begin
    is_mul_s    = (alucontrolE == MULT_CONTROL) || (alucontrolE == MULTU_CONTROL);
    is_div_s    = (alucontrolE == DIV_CONTROL)  || (alucontrolE == DIVU_CONTROL);
    op_signed_s = (alucontrolE == MULT_CONTROL) || (alucontrolE == DIV_CONTROL);
    start_s     = is_mul_s || is_div_s;
    // Restoring step: shift {rem,quo} left, trial-subtract the divisor.
    rem_shift_s = {rem_r, quo_r[31]};
    rem_diff_s  = rem_shift_s - {1'b0, mag_b_r};
    mult_s      = {32'd0, mag_a_r} * {32'd0, mag_b_r};
    prod_sel_s  = MUL_DIRECT ? mult_s : prod_r;
    // Sign flags are only ever set for signed ops, so unsigned ops pass through.
    prod_fix_s  = (sign_a_r ^ sign_b_r) ? (64'd0 - prod_sel_s) : prod_sel_s;
    quo_fix_s   = (sign_a_r ^ sign_b_r) ? (32'd0 - quo_r) : quo_r;
    rem_fix_s   = sign_a_r ? (32'd0 - rem_r) : rem_r;
    raw_a_s     = sign_a_r ? (32'd0 - mag_a_r) : mag_a_r;
    if (!is_div_r) begin
      commit_hi_s = prod_fix_s[63:32];
      commit_lo_s = prod_fix_s[31:0];
    end else if (mag_b_r == 32'd0) begin
      commit_hi_s = raw_a_s;
      commit_lo_s = 32'hFFFF_FFFF;
    end else begin
      commit_hi_s = rem_fix_s;
      commit_lo_s = quo_fix_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state, stall and completion-pulse logic.
  always_comb begin
    state_s   = state_r;
    stall_mdE = 1'b0;
    done_o    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s && !flushE) begin
          stall_mdE = 1'b1;
          if (is_div_s)        state_s = ST_DIV;
          else if (MUL_DIRECT) state_s = ST_DONE;
          else                 state_s = ST_MUL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flushE) begin
          state_s = ST_IDLE;
        end else begin
          stall_mdE = 1'b1;
          if (cnt_r == 6'd0) state_s = ST_DONE;
          else               state_s = state_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        done_o  = !flushE;
      end
      default: state_s = ST_IDLE;
    endcase
    // Reset forces the outputs low at once, even with a start code present.
    if (rst) begin
      stall_mdE = 1'b0;
      done_o    = 1'b0;
    end else begin
      stall_mdE = stall_mdE;
      done_o    = done_o;
    end
  end

  // Operand capture, iteration, HI/LO commit and MTHI/MTLO writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_r  <= 32'd0;
      mag_b_r  <= 32'd0;
      quo_r    <= 32'd0;
      rem_r    <= 32'd0;
      prod_r   <= 64'd0;
      cnt_r    <= 6'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      is_div_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!flushE) begin
            if (start_s) begin
              mag_a_r  <= mag32(srcaE, op_signed_s);
              mag_b_r  <= mag32(srcbE, op_signed_s);
              quo_r    <= mag32(srcaE, op_signed_s);
              rem_r    <= 32'd0;
              sign_a_r <= op_signed_s & srcaE[31];
              sign_b_r <= op_signed_s & srcbE[31];
              is_div_r <= is_div_s;
              cnt_r    <= is_div_s ? DIV_CNT_INIT : MUL_CNT_INIT;
            end else if (alucontrolE == MTHI_CONTROL) begin
              hi_r <= srcaE;
            end else if (alucontrolE == MTLO_CONTROL) begin
              lo_r <= srcaE;
            end
          end
        end
        ST_MUL: begin
          if (!flushE) begin
            prod_r <= mult_s;
            cnt_r  <= cnt_r - 6'd1;
          end
        end
        ST_DIV: begin
          if (!flushE) begin
            if (!rem_diff_s[32]) begin
              rem_r <= rem_diff_s[31:0];
              quo_r <= {quo_r[30:0], 1'b1};
            end else begin
              rem_r <= rem_shift_s[31:0];
              quo_r <= {quo_r[30:0], 1'b0};
            end
            cnt_r <= cnt_r - 6'd1;
          end
        end
        ST_DONE: begin
          if (!flushE) begin
            hi_r <= commit_hi_s;
            lo_r <= commit_lo_s;
          end
        end
        default: begin
          hi_r <= hi_r;
        end
      endcase
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;

  localparam int         MUL_LAT = 3;
  localparam logic [4:0] C_NOP   = 5'b00000;
  localparam logic [4:0] C_MULT  = 5'b01000;
  localparam logic [4:0] C_MULTU = 5'b01001;
  localparam logic [4:0] C_DIV   = 5'b01010;
  localparam logic [4:0] C_DIVU  = 5'b01011;
  localparam logic [4:0] C_MTHI  = 5'b01100;
  localparam logic [4:0] C_MTLO  = 5'b01101;

  logic        clk = 1'b0, rst = 1'b1, flushE = 1'b0;
  logic [4:0]  alucontrolE = 5'd0;
  logic [31:0] srcaE = 32'd0, srcbE = 32'd0;
  logic        stall_mdE, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0, bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_v;
  logic [31:0] act_hi, act_lo;
  int stall_n, done_c;

  muldiv_hilo_ctrl #(
    .MUL_LAT(MUL_LAT), .DIV_STEPS(32),
    .MULT_CONTROL(C_MULT), .MULTU_CONTROL(C_MULTU), .DIV_CONTROL(C_DIV),
    .DIVU_CONTROL(C_DIVU), .MTHI_CONTROL(C_MTHI), .MTLO_CONTROL(C_MTLO)
  ) dut (
    .clk(clk), .rst(rst), .alucontrolE(alucontrolE), .srcaE(srcaE), .srcbE(srcbE),
    .flushE(flushE), .stall_mdE(stall_mdE), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Reference model: {HI, LO} for one mul/div operation.
  function automatic logic [63:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      C_MULT:  return 64'(sa * sb);
      C_MULTU: return {32'd0, a} * {32'd0, b};
      C_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      C_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue one op at cycle 0 (called #1 after a rising edge); hold it until
  // the completion pulse, then capture HI/LO and pop the expected result.
  task automatic issue_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    alucontrolE = c; srcaE = a; srcbE = b;
    sb_q.push_back(model(c, a, b));
    stall_n = 0;
    done_c  = -1;
    for (int cyc = 0; cyc < 100 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (stall_mdE) stall_n++;
      if (done_o) done_c = cyc;
      @(posedge clk); #1;
    end
    alucontrolE = C_NOP;
    act_hi = hi_o;
    act_lo = lo_o;
    exp_v  = sb_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi_o); end
    total++; if (lo_o !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo_o); end
    total++; if (stall_mdE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_mdE); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_div();
    logic [4:0]  c[5]  = '{C_DIVU, C_DIV, C_DIV, C_DIVU, C_DIV};
    logic [31:0] a[5]  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000};
    logic [31:0] b[5]  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] lit[5] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {32'd1, 32'hFFFF_FFFD}, {32'd5, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}};
    for (int i = 0; i < 5; i++) begin
      issue_op(c[i], a[i], b[i]);
      total++; if (stall_n != 33) begin bad++; $display("FAIL div%0d_stall got=%0d want=33", i, stall_n); end
      total++; if (done_c != 33) begin bad++; $display("FAIL div%0d_done_cycle got=%0d want=33", i, done_c); end
      total++; if ({act_hi, act_lo} !== exp_v) begin bad++; $display("FAIL div%0d_hilo got=%h_%h want=%h", i, act_hi, act_lo, exp_v); end
      total++; if ({act_hi, act_lo} !== lit[i]) begin bad++; $display("FAIL div%0d_table got=%h_%h want=%h", i, act_hi, act_lo, lit[i]); end
    end
  endtask

  task automatic test_mult();
    logic [4:0]  c[2]   = '{C_MULT, C_MULTU};
    logic [63:0] lit[2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFE}, {32'd1, 32'hFFFF_FFFE}};
    for (int i = 0; i < 2; i++) begin
      issue_op(c[i], 32'hFFFF_FFFF, 32'd2);
      total++; if (stall_n != MUL_LAT) begin bad++; $display("FAIL mul%0d_stall got=%0d want=%0d", i, stall_n, MUL_LAT); end
      total++; if (done_c != MUL_LAT) begin bad++; $display("FAIL mul%0d_done_cycle got=%0d want=%0d", i, done_c, MUL_LAT); end
      total++; if ({act_hi, act_lo} !== exp_v) begin bad++; $display("FAIL mul%0d_hilo got=%h_%h want=%h", i, act_hi, act_lo, exp_v); end
      total++; if ({act_hi, act_lo} !== lit[i]) begin bad++; $display("FAIL mul%0d_table got=%h_%h want=%h", i, act_hi, act_lo, lit[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      c = (i % 4 == 0) ? C_MULT : (i % 4 == 1) ? C_MULTU : (i % 4 == 2) ? C_DIV : C_DIVU;
      a = $urandom;
      b = (i == 6) ? 32'd0 : $urandom;
      issue_op(c, a, b);
      total++; if ({act_hi, act_lo} !== exp_v) begin bad++; $display("FAIL b2b%0d_hilo op=%0d a=%h b=%h got=%h_%h want=%h", i, c, a, b, act_hi, act_lo, exp_v); end
    end
  endtask

  task automatic test_flush();
    alucontrolE = C_MTHI; srcaE = 32'h0000_1234;
    @(negedge clk);
    total++; if (stall_mdE !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL mthi_nostall got=%b%b want=00", stall_mdE, done_o); end
    @(posedge clk); #1;
    alucontrolE = C_MTLO; srcaE = 32'h0000_5678;
    total++; if (hi_o !== 32'h0000_1234) begin bad++; $display("FAIL mthi_write got=%h want=00001234", hi_o); end
    @(posedge clk); #1;
    total++; if (lo_o !== 32'h0000_5678) begin bad++; $display("FAIL mtlo_write got=%h want=00005678", lo_o); end
    alucontrolE = C_DIV; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flushE = 1'b1;
    @(negedge clk);
    total++; if (stall_mdE !== 1'b0) begin bad++; $display("FAIL flush_div_stall got=%b want=0", stall_mdE); end
    @(posedge clk); #1;
    flushE = 1'b0; alucontrolE = C_NOP;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || stall_mdE !== 1'b0) begin
        total++; bad++; $display("FAIL flush_div_idle cyc=%0d got=%b%b want=00", k, stall_mdE, done_o);
      end
    end
    total++; if ({hi_o, lo_o} !== {32'h0000_1234, 32'h0000_5678}) begin bad++; $display("FAIL flush_div_hilo got=%h_%h want=00001234_00005678", hi_o, lo_o); end
    // Flush landing on the completion cycle must suppress the commit.
    @(posedge clk); #1;
    alucontrolE = C_MULTU; srcaE = 32'd9; srcbE = 32'd9;
    repeat (MUL_LAT) begin @(posedge clk); #1; end
    flushE = 1'b1;
    @(negedge clk);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL flush_done_pulse got=%b want=0", done_o); end
    @(posedge clk); #1;
    flushE = 1'b0; alucontrolE = C_NOP;
    total++; if ({hi_o, lo_o} !== {32'h0000_1234, 32'h0000_5678}) begin bad++; $display("FAIL flush_done_hilo got=%h_%h want=00001234_00005678", hi_o, lo_o); end
  endtask

  task automatic test_rst_mid();
    alucontrolE = C_DIVU; srcaE = 32'd77; srcbE = 32'd5;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++; if ({hi_o, lo_o} !== 64'd0) begin bad++; $display("FAIL rst_mid_hilo got=%h_%h want=0", hi_o, lo_o); end
    total++; if (stall_mdE !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b want=0", stall_mdE); end
    @(posedge clk); #1;
    rst = 1'b0;
    alucontrolE = C_MTLO; srcaE = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if (stall_mdE !== 1'b0) begin bad++; $display("FAIL rst_mtlo_stall got=%b want=0", stall_mdE); end
    @(posedge clk); #1;
    alucontrolE = C_NOP;
    total++; if (lo_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_mtlo_lo got=%h want=cafef00d", lo_o); end
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL rst_mtlo_hi got=%h want=0", hi_o); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_mult();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
